// File: rtl/sqrt_pkg.sv
// Shared types for the non-restoring square-root engine.
// Holds default widths, the sequencer state encoding and root/remainder types.
package sqrt_pkg;

    localparam int DATA_W = 32;
    localparam int Q_W    = DATA_W / 2;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } sqrt_state_t;

    typedef logic        [Q_W-1:0] root_t;
    typedef logic signed [Q_W+1:0] rem_t;

endpackage

// File: rtl/sqrt_nr_step.sv
// One combinational non-restoring square-root iteration.
// Ports: r_i/q_i current remainder/root, pair_i next radicand bit pair,
//        rn_o/qn_o next remainder/root.
module sqrt_nr_step #(
    parameter int Q_W = 16
) (
    input  logic [Q_W+1:0] r_i,
    input  logic [Q_W-1:0] q_i,
    input  logic [1:0]     pair_i,
    output logic [Q_W+1:0] rn_o,
    output logic [Q_W-1:0] qn_o
);

    logic [Q_W+1:0] shifted;

    // Two's complement bit patterns: add/sub on raw bits, sign is the MSB.
    assign shifted = (r_i << 2) | {{Q_W{1'b0}}, pair_i};

    assign rn_o = r_i[Q_W+1] ? shifted + {q_i, 2'b11}
                             : shifted - {q_i, 2'b01};

    assign qn_o = {q_i[Q_W-2:0], ~rn_o[Q_W+1]};

endmodule

// File: rtl/sqrt_nr_engine.sv
// Iterative non-restoring integer square root, one root bit per clock.
// Ports: clk, rst (async active-high), init (start, samples D), D radicand,
//        Q root, R signed remainder, RDY idle/result valid, DONE 1-cycle pulse.
// Build option SQRT_REM_FIX_EN adds a FIX cycle so R is the true remainder.
module sqrt_nr_engine #(
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init,
    input  logic [DATA_W-1:0]          D,
    output logic [DATA_W/2-1:0]        Q,
    output logic signed [DATA_W/2+1:0] R,
    output logic                       RDY,
    output logic                       DONE
);

    import sqrt_pkg::*;

    localparam int Q_W   = DATA_W / 2;
    localparam int CNT_W = $clog2(Q_W);

    sqrt_state_t       state_q;
    logic [DATA_W-1:0] d_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [Q_W-1:0]    q_q;
    logic [Q_W-1:0]    q_d;
    logic [Q_W+1:0]    r_q;
    logic [Q_W+1:0]    r_d;
    logic              rdy_q;
    logic              done_q;
    logic [1:0]        pair;

    assign pair = d_q[{cnt_q, 1'b0} +: 2];

    sqrt_nr_step #(
        .Q_W (Q_W)
    ) u_step (
        .r_i    (r_q),
        .q_i    (q_q),
        .pair_i (pair),
        .rn_o   (r_d),
        .qn_o   (q_d)
    );

    // init restarts from any state; DONE output only flags the entry cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= sqrt_pkg::IDLE;
            d_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
        end else if (init) begin
            state_q <= sqrt_pkg::ITER;
            d_q     <= D;
            cnt_q   <= CNT_W'(Q_W - 1);
            q_q     <= '0;
            r_q     <= '0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                sqrt_pkg::ITER: begin
                    q_q <= q_d;
                    r_q <= r_d;
                    if (cnt_q == '0) begin
`ifdef SQRT_REM_FIX_EN
                        state_q <= sqrt_pkg::FIX;
`else
                        state_q <= sqrt_pkg::DONE;
                        rdy_q   <= 1'b1;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef SQRT_REM_FIX_EN
                sqrt_pkg::FIX: begin
                    // Negative raw remainder is short by 2Q+1.
                    if (r_q[Q_W+1]) begin
                        r_q <= r_q + {1'b0, q_q, 1'b1};
                    end
                    state_q <= sqrt_pkg::DONE;
                    rdy_q   <= 1'b1;
                    done_q  <= 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign RDY  = rdy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_sqrt_nr_engine.sv
// Self-checking bench for sqrt_nr_engine (DATA_W=32).
// Works with and without SQRT_REM_FIX_EN.
module tb_sqrt_nr_engine;

    logic               clk = 1'b0;
    logic               rst;
    logic               init;
    logic [31:0]        D;
    logic [15:0]        Q;
    logic signed [17:0] R;
    logic               RDY;
    logic               DONE;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SQRT_REM_FIX_EN
    localparam int LAT = 17;
    localparam logic signed [17:0] R0   = 18'sd0;
    localparam logic signed [17:0] R16  = 18'sd0;
    localparam logic signed [17:0] R17  = 18'sd1;
    localparam logic signed [17:0] R100 = 18'sd0;
`else
    localparam int LAT = 16;
    localparam logic signed [17:0] R0   = -18'sd1;
    localparam logic signed [17:0] R16  = -18'sd9;
    localparam logic signed [17:0] R17  = -18'sd8;
    localparam logic signed [17:0] R100 = -18'sd21;
`endif

    sqrt_nr_engine #(
        .DATA_W (32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .D    (D),
        .Q    (Q),
        .R    (R),
        .RDY  (RDY),
        .DONE (DONE)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic longint isqrt(input longint d);
        longint r;
        longint t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= d) r = t;
        end
        return r;
    endfunction

    // Called at a negedge; init is sampled on the following posedge.
    task automatic do_init(input logic [31:0] d);
        init = 1'b1;
        D    = d;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        init = 1'b0;
        D    = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Q !== 16'h0 || R !== 18'sd0 || RDY !== 1'b1 || DONE !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: Q=%h R=%h RDY=%b DONE=%b want 0 0 1 0",
                     Q, R, RDY, DONE);
        end
        init = 1'b1;
        D    = 32'hFFFF_FFFF;
        @(negedge clk);
        n_cmp++;
        if (RDY !== 1'b1 || Q !== 16'h0 || R !== 18'sd0) begin
            n_bad++;
            $display("FAIL rst_beats_init: RDY=%b Q=%h R=%h want 1 0 0",
                     RDY, Q, R);
        end
        init = 1'b0;
        rst  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (RDY !== 1'b1 || DONE !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_hold: RDY=%b DONE=%b want 1 0", RDY, DONE);
        end
    endtask

    task automatic test_zero;
        int bad;
        do_init(32'd0);
        n_cmp++;
        if (RDY !== 1'b0) begin
            n_bad++;
            $display("FAIL rdy_fall: RDY=%b want 0", RDY);
        end
        bad = 0;
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            if (RDY !== 1'b0 || DONE !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL latency_low: %0d early cycles want 0", bad);
        end
        @(negedge clk);
        n_cmp++;
        if (RDY !== 1'b1 || DONE !== 1'b1 || Q !== 16'h0 || R !== R0) begin
            n_bad++;
            $display("FAIL zero_result: RDY=%b DONE=%b Q=%h R=%0d want 1 1 0 %0d",
                     RDY, DONE, Q, R, R0);
        end
        @(negedge clk);
        n_cmp++;
        if (DONE !== 1'b0 || RDY !== 1'b1 || Q !== 16'h0 || R !== R0) begin
            n_bad++;
            $display("FAIL done_pulse: DONE=%b RDY=%b Q=%h R=%0d want 0 1 0 %0d",
                     DONE, RDY, Q, R, R0);
        end
    endtask

    task automatic test_boundaries;
        logic [31:0]        td [4];
        logic [15:0]        tq [4];
        logic signed [17:0] tr [4];
        td = '{32'd16, 32'd17, 32'hFFFF_FFFF, 32'd100};
        tq = '{16'd4, 16'd4, 16'hFFFF, 16'd10};
        tr = '{R16, R17, 18'sh1FFFE, R100};
        for (int i = 0; i < 4; i++) begin
            do_init(td[i]);
            repeat (LAT) @(negedge clk);
            n_cmp++;
            if (Q !== tq[i] || R !== tr[i] || RDY !== 1'b1) begin
                n_bad++;
                $display("FAIL vec%0d D=%h: Q=%h R=%0d RDY=%b want %h %0d 1",
                         i, td[i], Q, R, RDY, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_reinit;
        int bad;
        bad = 0;
        do_init(32'd1000);
        repeat (4) begin
            @(negedge clk);
            if (RDY !== 1'b0 || DONE !== 1'b0) bad++;
        end
        do_init(32'd100);
        if (RDY !== 1'b0 || DONE !== 1'b0) bad++;
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            if (RDY !== 1'b0 || DONE !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL reinit_rdy: %0d early cycles want 0", bad);
        end
        @(negedge clk);
        n_cmp++;
        if (RDY !== 1'b1 || DONE !== 1'b1 || Q !== 16'd10 || R !== R100) begin
            n_bad++;
            $display("FAIL reinit_result: RDY=%b DONE=%b Q=%0d R=%0d want 1 1 10 %0d",
                     RDY, DONE, Q, R, R100);
        end
    endtask

    task automatic test_done_drop;
        do_init(32'd17);
        n_cmp++;
        if (DONE !== 1'b0 || RDY !== 1'b0) begin
            n_bad++;
            $display("FAIL done_drop: DONE=%b RDY=%b want 0 0", DONE, RDY);
        end
        repeat (LAT) @(negedge clk);
    endtask

    task automatic test_rst_mid;
        do_init(32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (Q !== 16'h000F) begin
            n_bad++;
            $display("FAIL pre_rst_q: Q=%h want 000f", Q);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (Q !== 16'h0 || R !== 18'sd0 || RDY !== 1'b1 || DONE !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: Q=%h R=%h RDY=%b DONE=%b want 0 0 1 0",
                     Q, R, RDY, DONE);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (Q !== 16'h0 || R !== 18'sd0 || RDY !== 1'b1 || DONE !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_idle: Q=%h R=%h RDY=%b DONE=%b want 0 0 1 0",
                     Q, R, RDY, DONE);
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 1500;
        logic [31:0] cur;
        logic [31:0] nxt;
        longint      dv;
        longint      qe;
        longint      rv;
        longint      rt;
        int          k;
        int          rdy_bad;
        rdy_bad = 0;
        cur = $urandom;
        do_init(cur);
        for (int i = 0; i < N; i++) begin
            k = 0;
            while (DONE !== 1'b1 && k < LAT + 4) begin
                if (RDY !== 1'b0) rdy_bad++;
                @(negedge clk);
                k++;
            end
            n_cmp++;
            if (k != LAT) begin
                n_bad++;
                $display("FAIL b2b_latency #%0d: %0d cycles want %0d", i, k, LAT);
            end
            dv = longint'(cur);
            qe = isqrt(dv);
            rv = longint'(R);
`ifdef SQRT_REM_FIX_EN
            rt = rv;
`else
            rt = (rv < 0) ? rv + 2 * qe + 1 : rv;
`endif
            n_cmp++;
            if (longint'(Q) != qe) begin
                n_bad++;
                $display("FAIL b2b_q D=%h: Q=%h want %h", cur, Q, qe);
            end
            n_cmp++;
            if (rt != dv - qe * qe) begin
                n_bad++;
                $display("FAIL b2b_r D=%h: R=%0d want rem %0d", cur, R, dv - qe * qe);
            end
            if (i < N - 1) begin
                nxt = $urandom;
                cur = nxt;
                do_init(cur);
            end
        end
        n_cmp++;
        if (rdy_bad != 0) begin
            n_bad++;
            $display("FAIL b2b_rdy: %0d cycles with RDY=1 mid-iteration", rdy_bad);
        end
    endtask

    initial begin
        rst  = 1'b1;
        init = 1'b0;
        D    = '0;
        @(negedge clk);
        test_reset;
        test_zero;
        test_boundaries;
        test_reinit;
        test_done_drop;
        test_rst_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
